prog_streamer: RTL



---
 rtl/prog_streamer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/prog_streamer.sv
// Streams a preloaded program word-by-word onto the processor D input, advancing on IRin/Ext consumes.
// D_out is combinational from registered PC; loads are only accepted while IDLE/HALT, otherwise flagged in err.
module prog_streamer #(
   parameter int W     = 10,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          CLKb,
   input  logic          CLRn,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [W-1:0]  load_data,
   input  logic          len_en,
   input  logic [AW:0]   load_len,
   input  logic          start,
   input  logic          IRin,
   input  logic          Ext,
   input  logic          Clr,
   output logic [W-1:0]  D_out,
   output logic [AW:0]   PC,
   output logic          busy,
   output logic          halted,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t        state_q, state_d;
   logic [AW:0]   pc_q, pc_d;
   logic [AW:0]   len_q, len_d;
   logic          err_q, err_d;
   logic [W-1:0]  mem_q [DEPTH];

   logic consume;
   logic loadable;

   assign consume  = IRin | Ext;
   assign loadable = (state_q == S_IDLE) || (state_q == S_HALT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      len_d   = len_q;
      err_d   = err_q;

      if ((load_en || len_en) && !loadable) begin
         err_d = 1'b1;
      end
      if (len_en && loadable) begin
         len_d = (load_len > DEPTH_L) ? DEPTH_L : load_len;
      end

      case (state_q)
         S_IDLE, S_HALT: begin
            // start decision deliberately uses the old length, even if len_en fires now
            if (start) begin
               pc_d    = '0;
               state_d = (len_q != '0) ? S_RUN : S_HALT;
            end
         end
         S_RUN: begin
            if (consume) begin
               pc_d = pc_q + 1'b1;
               if (IRin && Ext) begin
                  err_d = 1'b1;
               end
               if ((pc_q + 1'b1) == len_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (consume) begin
               err_d = 1'b1;
            end
            if (Clr) begin
               state_d = S_HALT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLKb or negedge CLRn) begin
      if (!CLRn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge CLKb or negedge CLRn) begin
      if (!CLRn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (load_en && loadable) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // PC < len <= DEPTH whenever RUN, so the low AW bits are a safe read address
   assign D_out  = (state_q == S_RUN) ? mem_q[pc_q[AW-1:0]] : '0;
   assign PC     = pc_q;
   assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign halted = (state_q == S_HALT);
   assign err    = err_q;

endmodule
